// File: rtl/rc4_keystream_decrypt.sv
// RC4 keystream generator and decryptor: walks the PRGA over an external S-box RAM,
// XORs each keystream byte with the encrypted ROM and reports whether all plaintext was printable.
module rc4_keystream_decrypt #(
    parameter int RAM_WIDTH  = 8,
    parameter int MSG_LENGTH = 32,
    parameter int MSG_AW     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_sig,
    input  logic [RAM_WIDTH-1:0] s_ram_out,
    output logic [RAM_WIDTH-1:0] s_address,
    output logic [RAM_WIDTH-1:0] s_ram_in,
    output logic                 s_write_enable,
    output logic [MSG_AW-1:0]    enc_address,
    input  logic [RAM_WIDTH-1:0] enc_out,
    output logic [MSG_AW-1:0]    dec_address,
    output logic [RAM_WIDTH-1:0] dec_in,
    output logic                 dec_write_enable,
    output logic                 decrypt_finished,
    output logic                 key_valid,
    output logic [3:0]           state_tap
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_I   = 4'd1,
        GET_SI = 4'd2,
        RD_J   = 4'd3,
        GET_SJ = 4'd4,
        WR_I   = 4'd5,
        WR_J   = 4'd6,
        RD_F   = 4'd7,
        GET_F  = 4'd8,
        WR_K   = 4'd9
    } state_t;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LENGTH - 1);

    state_t               r_state;
    state_t               w_next;
    logic [RAM_WIDTH-1:0] r_i, r_j, r_si, r_sj, r_f, r_e;
    logic [MSG_AW-1:0]    r_k;
    logic                 r_finished, r_valid;
    logic [RAM_WIDTH-1:0] w_plain;
    logic                 w_printable;
    logic                 w_last;

    assign w_plain     = r_f ^ r_e;
    assign w_printable = ((w_plain >= RAM_WIDTH'(8'h61)) && (w_plain <= RAM_WIDTH'(8'h7A)))
                       || (w_plain == RAM_WIDTH'(8'h20));
    assign w_last      = (r_k == K_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next           = r_state;
        s_address        = '0;
        s_ram_in         = '0;
        s_write_enable   = 1'b0;
        enc_address      = '0;
        dec_address      = '0;
        dec_in           = '0;
        dec_write_enable = 1'b0;
        case (r_state)
            IDLE:   if (start_sig) w_next = RD_I;
            RD_I:   begin s_address = r_i; w_next = GET_SI; end
            GET_SI: w_next = RD_J;
            RD_J:   begin s_address = r_j; w_next = GET_SJ; end
            GET_SJ: w_next = WR_I;
            WR_I: begin
                s_address      = r_i;
                s_ram_in       = r_sj;
                s_write_enable = 1'b1;
                w_next         = WR_J;
            end
            WR_J: begin
                s_address      = r_j;
                s_ram_in       = r_si;
                s_write_enable = 1'b1;
                w_next         = RD_F;
            end
            // si+sj equals S[i]+S[j] after the swap, so the read sees the swapped table
            RD_F: begin
                s_address   = r_si + r_sj;
                enc_address = r_k;
                w_next      = GET_F;
            end
            GET_F:  w_next = WR_K;
            WR_K: begin
                dec_address      = r_k;
                dec_in           = w_plain;
                dec_write_enable = 1'b1;
                w_next           = (!w_printable || w_last) ? IDLE : RD_I;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_si       <= '0;
            r_sj       <= '0;
            r_f        <= '0;
            r_e        <= '0;
            r_finished <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start_sig) begin
                    r_i        <= RAM_WIDTH'(1);
                    r_j        <= '0;
                    r_k        <= '0;
                    r_finished <= 1'b0;
                    r_valid    <= 1'b0;
                end
                GET_SI: begin
                    r_si <= s_ram_out;
                    r_j  <= r_j + s_ram_out;
                end
                GET_SJ: r_sj <= s_ram_out;
                GET_F: begin
                    r_f <= s_ram_out;
                    r_e <= enc_out;
                end
                WR_K: begin
                    if (!w_printable) begin
                        r_finished <= 1'b1;
                        r_valid    <= 1'b0;
                    end else if (w_last) begin
                        r_finished <= 1'b1;
                        r_valid    <= 1'b1;
                    end else begin
                        r_i <= r_i + RAM_WIDTH'(1);
                        r_k <= r_k + MSG_AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign decrypt_finished = r_finished;
    assign key_valid        = r_valid;
    assign state_tap        = r_state;

endmodule
